// File: rtl/reg_ar_seq_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : reg_ar_seq_if                                                 |
// | Brief    : Bus-cycle request/strobe bundle between reg_ar_seq and bus.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface reg_ar_seq_if #(
    parameter int NDEV = 4
);
    logic            nmem;
    logic            nio;
    logic            nwait;
    logic            nmemstb;
    logic            niostb;
    logic [NDEV-1:0] ndev;
    logic            nbusy;
    logic            berr;

    modport master (
        input  nmem, nio, nwait,
        output nmemstb, niostb, ndev, nbusy, berr
    );

    modport slave (
        output nmem, nio, nwait,
        input  nmemstb, niostb, ndev, nbusy, berr
    );
endinterface
`default_nettype wire

// File: rtl/reg_ar_seq.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : reg_ar_seq                                                    |
// | Brief    : Address register with bus-cycle sequencer and registered      |
// |            memory / I/O / device-window strobes. Optional macro          |
// |            REG_AR_FPFULL_EN adds full front-panel AR readout.            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module reg_ar_seq #(
    parameter int AW     = 24,
    parameter int IOW    = 10,
    parameter int WSHIFT = 8,
    parameter int NDEV   = 4,
    parameter int SETUP  = 1
) (
    input  wire           clk,
    input  wire           nreset,
    input  wire           halt,
    input  wire [15:0]    ibus,
    input  wire [AW-17:0] aext,
    input  wire           nwrite_ar,
    input  wire           ninc_ar,
    reg_ar_seq_if.master  bus,
    output wire [AW-1:0]  ab,
    input  wire           nfparh,
`ifdef REG_AR_FPFULL_EN
    input  wire           nfparm,
    input  wire           nfparl,
`endif
    output wire [7:0]     fpd
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_STROBE = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    localparam logic [AW-1:0] c_ar_one     = AW'(1);
    localparam logic [1:0]    c_setup_last = 2'(SETUP - 1);
    localparam int            c_winw       = IOW - WSHIFT;

    state_t          r_state, w_state_next;
    logic [AW-1:0]   r_ar, r_abuf;
    logic [1:0]      r_cnt, w_cnt_next;
    logic            r_rel, w_rel_next;
    logic            r_is_io;
    logic            r_nmem_q, r_nio_q, r_nwait_q;
    logic            r_berr;
    logic            r_nmemstb, r_niostb;
    logic [NDEV-1:0] r_ndev;
    logic            w_start, w_berr_set;
    logic            w_req_mem, w_req_io, w_req_live, w_released;
    logic            w_strobe_next, w_io_hit;
    logic [c_winw-1:0] w_win;
    logic [NDEV-1:0] w_dev_hit;
    logic [AW-1:0]   w_ab;
    logic [7:0]      w_fp_h;

    // Requests and nwait pass through one sampling stage; the FSM acts on these.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_nmem_q  <= 1'b1;
            r_nio_q   <= 1'b1;
            r_nwait_q <= 1'b1;
        end else begin
            r_nmem_q  <= bus.nmem;
            r_nio_q   <= bus.nio;
            r_nwait_q <= bus.nwait;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_ar <= '0;
        end else if (!nwrite_ar) begin
            r_ar <= {aext, ibus};
        end else if (!ninc_ar) begin
            r_ar <= r_ar + c_ar_one;
        end
    end

    assign w_req_mem  = !r_nmem_q;
    assign w_req_io   = !r_nio_q;
    assign w_req_live = r_is_io ? w_req_io : w_req_mem;
    assign w_released = r_rel | !w_req_live;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= S_IDLE;
            r_cnt   <= 2'd0;
            r_rel   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_rel   <= w_rel_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_rel_next   = r_rel;
        w_start      = 1'b0;
        w_berr_set   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req_mem && w_req_io) begin
                    w_berr_set = 1'b1;
                end else if (w_req_mem ^ w_req_io) begin
                    w_state_next = S_SETUP;
                    w_start      = 1'b1;
                    w_cnt_next   = 2'd0;
                    w_rel_next   = 1'b0;
                end
            end
            S_SETUP: begin
                if (!w_req_live) w_rel_next = 1'b1;
                if (r_cnt == c_setup_last) begin
                    w_state_next = w_released ? S_HOLD : S_STROBE;
                end else begin
                    w_cnt_next = r_cnt + 2'd1;
                end
            end
            S_STROBE: begin
                if (!w_req_live) w_rel_next = 1'b1;
                if (w_released && r_nwait_q) w_state_next = S_HOLD;
            end
            S_HOLD:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_io_hit = ((r_abuf[15:0] >> IOW) == 16'd0);
    assign w_win    = r_abuf[IOW-1:WSHIFT];

    for (genvar k = 0; k < NDEV; k++) begin : g_dev
        assign w_dev_hit[k] = w_io_hit && (w_win == c_winw'(k));
    end

    // Strobes are registered from the next state so each output is a clean flop.
    assign w_strobe_next = (w_state_next == S_STROBE);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_abuf    <= '0;
            r_is_io   <= 1'b0;
            r_berr    <= 1'b0;
            r_nmemstb <= 1'b1;
            r_niostb  <= 1'b1;
            r_ndev    <= '1;
        end else begin
            if (w_start) begin
                r_abuf  <= r_ar;
                r_is_io <= w_req_io;
            end
            if (w_berr_set) r_berr <= 1'b1;
            r_nmemstb <= !(w_strobe_next && !r_is_io);
            r_niostb  <= !(w_strobe_next && r_is_io);
            r_ndev    <= ~({NDEV{w_strobe_next && r_is_io}} & w_dev_hit);
        end
    end

    assign bus.nmemstb = r_nmemstb | halt;
    assign bus.niostb  = r_niostb | halt;
    assign bus.ndev    = r_ndev | {NDEV{halt}};
    assign bus.nbusy   = (r_state == S_IDLE);
    assign bus.berr    = r_berr;

    assign w_ab = (r_state == S_IDLE) ? r_ar : r_abuf;
    assign ab   = halt ? {AW{1'bz}} : w_ab;

    if (AW >= 24) begin : g_fph_full
        assign w_fp_h = r_ar[23:16];
    end else begin : g_fph_pad
        assign w_fp_h = 8'(r_ar[AW-1:16]);
    end

`ifdef REG_AR_FPFULL_EN
    assign fpd = !nfparh ? w_fp_h     :
                 !nfparm ? r_ar[15:8] :
                 !nfparl ? r_ar[7:0]  : 8'bz;
`else
    assign fpd = nfparh ? 8'bz : w_fp_h;
`endif
endmodule
`default_nettype wire

// File: tb/tb_reg_ar_seq.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_reg_ar_seq                                                 |
// | Brief    : Scoreboard bench for reg_ar_seq with directed bus cycles.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_reg_ar_seq;
    localparam int SETUP = 1;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        halt = 1'b0;
    logic [15:0] ibus = 16'h0;
    logic [7:0]  aext = 8'h0;
    logic        nwrite_ar = 1'b1;
    logic        ninc_ar = 1'b1;
    logic        nfparh = 1'b1;
`ifdef REG_AR_FPFULL_EN
    logic        nfparm = 1'b1;
    logic        nfparl = 1'b1;
`endif
    wire  [23:0] ab;
    wire  [7:0]  fpd;

    reg_ar_seq_if #(.NDEV(4)) bus ();

    reg_ar_seq #(
        .AW(24), .IOW(10), .WSHIFT(8), .NDEV(4), .SETUP(SETUP)
    ) dut (
        .clk(clk), .nreset(nreset), .halt(halt), .ibus(ibus), .aext(aext),
        .nwrite_ar(nwrite_ar), .ninc_ar(ninc_ar), .bus(bus), .ab(ab),
        .nfparh(nfparh),
`ifdef REG_AR_FPFULL_EN
        .nfparm(nfparm), .nfparl(nfparl),
`endif
        .fpd(fpd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          start;
        int          len;
        logic [23:0] addr;
        logic [1:0]  kind;
        logic [3:0]  dev;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    bit   in_stb = 1'b0;
    int   len = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: one scoreboard entry per observed strobe pulse.
    initial begin
        logic any;
        forever begin
            @(negedge clk);
            if (!nreset) begin
                in_stb = 1'b0;
            end else if (halt) begin
                if (in_stb) len++;
            end else begin
                any = !bus.nmemstb || !bus.niostb || (bus.ndev != 4'hF);
                if (any && !in_stb) begin
                    in_stb = 1'b1;
                    len    = 1;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_strobe: ab %h ndev %b", ab, bus.ndev);
                        cur = '{start: cyc, len: 0, addr: ab, kind: {bus.nmemstb, bus.niostb}, dev: bus.ndev};
                    end else begin
                        cur = sb.pop_front();
                        check("strobe_start_cycle", cyc, cur.start);
                        check("strobe_ab", ab, cur.addr);
                        check("strobe_kind", {bus.nmemstb, bus.niostb}, cur.kind);
                        check("strobe_ndev", bus.ndev, cur.dev);
                    end
                end else if (any) begin
                    len++;
                    check("strobe_ab_stable", ab, cur.addr);
                    check("strobe_ndev_stable", bus.ndev, cur.dev);
                end else if (in_stb) begin
                    in_stb = 1'b0;
                    check("strobe_len", len, cur.len);
                end
            end
        end
    end

    task automatic load_ar(input logic [23:0] v);
        aext      = v[23:16];
        ibus      = v[15:0];
        nwrite_ar = 1'b0;
        @(negedge clk);
        nwrite_ar = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk);
            #1;
            done = bus.nbusy;
        end
        check(name, done, 1);
    endtask

    task automatic bus_cycle(input bit io, input logic [23:0] addr, input logic [3:0] dev,
                             input int hold, input int waits, input int exp_len,
                             input bit reload, input logic [23:0] rv);
        exp_t e;
        load_ar(addr);
        e.start = cyc + 2 + SETUP;
        e.len   = exp_len;
        e.addr  = addr;
        e.kind  = io ? 2'b10 : 2'b01;
        e.dev   = dev;
        sb.push_back(e);
        if (io) bus.nio = 1'b0;
        else    bus.nmem = 1'b0;
        repeat (hold) @(negedge clk);
        bus.nio   = 1'b1;
        bus.nmem  = 1'b1;
        bus.nwait = (waits == 0);
        if (reload) begin
            aext      = rv[23:16];
            ibus      = rv[15:0];
            nwrite_ar = 1'b0;
        end
        for (int i = 0; i < ((waits > 0) ? waits : 1); i++) begin
            @(negedge clk);
            nwrite_ar = 1'b1;
        end
        bus.nwait = 1'b1;
        wait_idle("cycle_return_idle");
    endtask

    // Directed vectors: {io, address, expected ndev}
    logic        v_io  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [23:0] v_adr [6] = '{24'h123456, 24'h000000, 24'h0001A5, 24'h0002FF, 24'h0003C0, 24'h000400};
    logic [3:0]  v_dev [6] = '{4'b1111, 4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1111};
    int          v_hld [6] = '{4, 2, 2, 2, 2, 2};
    int          v_len [6] = '{3, 1, 1, 1, 1, 1};

    initial begin
        exp_t e;
        bus.nmem  = 1'b1;
        bus.nio   = 1'b1;
        bus.nwait = 1'b1;

        #95;
        check("reset_ab", ab, 24'h000000);
        check("reset_nmemstb", bus.nmemstb, 1);
        check("reset_niostb", bus.niostb, 1);
        check("reset_ndev", bus.ndev, 4'hF);
        check("reset_nbusy", bus.nbusy, 1);
        check("reset_berr", bus.berr, 0);
        @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++)
            bus_cycle(v_io[i], v_adr[i], v_dev[i], v_hld[i], 0, v_len[i], 1'b0, 24'h0);

        load_ar(24'hFFFFFF);
        ninc_ar = 1'b0;
        @(negedge clk);
        ninc_ar = 1'b1;
        #1 check("inc_wrap", ab, 24'h000000);
        load_ar(24'h00FFFF);
        ninc_ar = 1'b0;
        @(negedge clk);
        ninc_ar = 1'b1;
        #1 check("inc_carry", ab, 24'h010000);
        aext = 8'h34; ibus = 16'h5678; nwrite_ar = 1'b0; ninc_ar = 1'b0;
        @(negedge clk);
        nwrite_ar = 1'b1; ninc_ar = 1'b1;
        #1 check("load_beats_inc", ab, 24'h345678);

        // Request dropped after one sample: sequencer runs to HOLD without strobing.
        @(negedge clk);
        bus.nmem = 1'b0;
        @(negedge clk);
        bus.nmem = 1'b1;
        @(negedge clk);
        #1 check("setup_busy", bus.nbusy, 0);
        wait_idle("setup_abort_idle");

        bus_cycle(1'b0, 24'h00ABCD, 4'hF, 3, 3, 5, 1'b1, 24'h555555);
        #1 check("ab_after_reload", ab, 24'h555555);

        // Halt in the middle of an I/O strobe to window 1.
        load_ar(24'h0001A5);
        e = '{start: cyc + 2 + SETUP, len: 4, addr: 24'h0001A5, kind: 2'b10, dev: 4'b1101};
        sb.push_back(e);
        bus.nio = 1'b0;
        repeat (3) @(negedge clk);
        #2 halt = 1'b1;
        #1;
        check("halt_niostb", bus.niostb, 1);
        check("halt_ndev", bus.ndev, 4'hF);
        check("halt_fsm_runs", bus.nbusy, 0);
        @(negedge clk);
        #2 halt = 1'b0;
        @(negedge clk);
        bus.nio = 1'b1;
        wait_idle("halt_cycle_idle");

        load_ar(24'hAB0000);
        nfparh = 1'b0;
        #1 check("fp_high", fpd, 8'hAB);
        nfparh = 1'b1;
`ifdef REG_AR_FPFULL_EN
        load_ar(24'hAB1234);
        nfparm = 1'b0;
        #1 check("fp_mid", fpd, 8'h12);
        nfparl = 1'b0;
        #1 check("fp_mid_over_low", fpd, 8'h12);
        nfparm = 1'b1;
        #1 check("fp_low", fpd, 8'h34);
        nfparl = 1'b1;
`endif

        @(negedge clk);
        bus.nmem = 1'b0;
        bus.nio  = 1'b0;
        @(negedge clk);
        bus.nmem = 1'b1;
        bus.nio  = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("berr_set", bus.berr, 1);
        check("berr_stays_idle", bus.nbusy, 1);

        // Asynchronous reset while a memory strobe is active.
        load_ar(24'h00F00F);
        e = '{start: cyc + 2 + SETUP, len: 0, addr: 24'h00F00F, kind: 2'b01, dev: 4'hF};
        sb.push_back(e);
        bus.nmem = 1'b0;
        repeat (3) @(negedge clk);
        #2 nreset = 1'b0;
        #1;
        check("async_rst_nmemstb", bus.nmemstb, 1);
        check("async_rst_ab", ab, 24'h000000);
        check("async_rst_berr", bus.berr, 0);
        check("async_rst_nbusy", bus.nbusy, 1);
        bus.nmem = 1'b1;
        @(negedge clk);
        nreset = 1'b1;
        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
